// File: rtl/kernel_filter_pkg.sv
// Shared sizing helpers and reset constants for the kernel filter pipeline.
package kernel_filter_pkg;

  // Coefficient value placed at the window centre after reset (identity filter).
  localparam int IDENT_CENTRE_COEF = 1;

  // Width of one pixel x coefficient product: zero-extended pixel times signed coef.
  function automatic int prod_width(input int data_size, input int coef_size);
    return data_size + coef_size + 1;
  endfunction

  // Accumulator width: product width plus growth for summing every tap.
  function automatic int acc_width(input int data_size, input int coef_size,
                                   input int kernel_size);
    return prod_width(data_size, coef_size) + $clog2(kernel_size * kernel_size);
  endfunction

  // Reset value of tap idx (row-major) for the identity kernel.
  function automatic int ident_coef(input int idx, input int kernel_size);
    return (idx == (kernel_size * kernel_size) / 2) ? IDENT_CENTRE_COEF : 0;
  endfunction

endpackage

// File: rtl/kernel_adder_tree.sv
// Combinational balanced adder tree summing COUNT signed terms into OUT_W bits.
module kernel_adder_tree #(
  parameter int COUNT = 9,
  parameter int IN_W  = 14,
  parameter int OUT_W = 18
)(
  input  logic signed [IN_W-1:0]  i_terms [COUNT],
  output logic signed [OUT_W-1:0] o_sum
);

  localparam int LEVELS = (COUNT > 1) ? $clog2(COUNT) : 0;
  localparam int LEAVES = 1 << LEVELS;

  logic signed [OUT_W-1:0] node [LEAVES];

  // Sign-extend the terms into a power-of-two leaf row, then fold pairwise.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < COUNT; i++) begin
      node[i] = OUT_W'(i_terms[i]);
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int i = 0; i < (LEAVES >> (lvl + 1)); i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    o_sum = node[0];
  end

endmodule

// File: rtl/kernel_filter_pipe.sv
// Three-stage KxK convolution kernel: products, sum, round/shift/clamp,
// with valid/ready flow control and a run-time writable coefficient bank.
module kernel_filter_pipe
  import kernel_filter_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int COEF_SIZE   = 5
)(
  input  logic                                         i_clk,
  input  logic                                         i_nrst,
  input  logic                                         i_valid,
  output logic                                         o_ready,
  input  logic [DATA_SIZE-1:0]                         i_data [KERNEL_SIZE][KERNEL_SIZE],
  input  logic [3:0]                                   i_shift,
  input  logic                                         i_coef_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]   i_coef_addr,
  input  logic signed [COEF_SIZE-1:0]                  i_coef_data,
  output logic                                         o_valid,
  input  logic                                         i_ready,
  output logic [DATA_SIZE-1:0]                         o_data,
  output logic                                         o_sat
);

  localparam int NTAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ADDR_W = $clog2(NTAPS);
  localparam int PROD_W = prod_width(DATA_SIZE, COEF_SIZE);
  localparam int ACC_W  = acc_width(DATA_SIZE, COEF_SIZE, KERNEL_SIZE);
  // One spare bit so adding the rounding bias can never wrap.
  localparam int RND_W  = ACC_W + 1;

  logic                     adv;
  logic signed [COEF_SIZE-1:0] coef_reg [NTAPS];

  logic signed [PROD_W-1:0] prod_next [NTAPS];
  logic signed [PROD_W-1:0] prod_reg  [NTAPS];
  logic                     v1_reg;
  logic [3:0]               shift1_reg;

  logic signed [ACC_W-1:0]  sum_next;
  logic signed [ACC_W-1:0]  sum_reg;
  logic                     v2_reg;
  logic [3:0]               shift2_reg;

  logic [RND_W-1:0]         round_bias;
  logic signed [RND_W-1:0]  rounded;
  logic signed [RND_W-1:0]  shifted;
  logic [DATA_SIZE-1:0]     data_next;
  logic                     sat_next;

  logic                     out_valid_reg;
  logic [DATA_SIZE-1:0]     out_data_reg;
  logic                     out_sat_reg;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv     = !out_valid_reg || i_ready;
  assign o_ready = adv;
  assign o_valid = out_valid_reg;
  assign o_data  = out_data_reg;
  assign o_sat   = out_sat_reg;

  // Coefficient bank: writes land regardless of stalls; out-of-range taps never match.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_reg[i] <= COEF_SIZE'(ident_coef(i, KERNEL_SIZE));
      end
    end else if (i_coef_we) begin
      for (int i = 0; i < NTAPS; i++) begin
        if (i_coef_addr == ADDR_W'(i)) begin
          coef_reg[i] <= i_coef_data;
        end
      end
    end
  end

  // Per-tap product; pixels are unsigned so a zero bit is prepended before signing.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    assign prod_next[gi] =
      PROD_W'($signed({1'b0, i_data[gi / KERNEL_SIZE][gi % KERNEL_SIZE]})) *
      PROD_W'(coef_reg[gi]);
  end

  // Stage 1: capture products with the coefficients held before any same-cycle write.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      v1_reg     <= 1'b0;
      shift1_reg <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        prod_reg[i] <= '0;
      end
    end else if (adv) begin
      v1_reg     <= i_valid;
      shift1_reg <= i_shift;
      prod_reg   <= prod_next;
    end
  end

  kernel_adder_tree #(
    .COUNT (NTAPS),
    .IN_W  (PROD_W),
    .OUT_W (ACC_W)
  ) u_adder_tree (
    .i_terms (prod_reg),
    .o_sum   (sum_next)
  );

  // Stage 2: register the window sum and carry the window's shift along.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      v2_reg     <= 1'b0;
      sum_reg    <= '0;
      shift2_reg <= '0;
    end else if (adv) begin
      v2_reg     <= v1_reg;
      sum_reg    <= sum_next;
      shift2_reg <= shift1_reg;
    end
  end

  // Round half-up, arithmetic shift, then clamp into the unsigned pixel range.
  always_comb begin
    round_bias = (RND_W'(1) << shift2_reg) >> 1;
    rounded    = RND_W'(sum_reg) + $signed(round_bias);
    shifted    = rounded >>> shift2_reg;
    data_next  = shifted[DATA_SIZE-1:0];
    sat_next   = 1'b0;
    if (shifted[RND_W-1]) begin
      data_next = '0;
      sat_next  = 1'b1;
    end else if (|shifted[RND_W-2:DATA_SIZE]) begin
      data_next = '1;
      sat_next  = 1'b1;
    end
  end

  // Stage 3: output register, frozen while downstream holds off.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (adv) begin
      out_valid_reg <= v2_reg;
      out_data_reg  <= data_next;
      out_sat_reg   <= sat_next;
    end
  end

endmodule
